// File: rtl/dmem_block_responder.sv
// dmem_block_responder: 64x4-byte block memory with LATENCY-cycle busywait handshake; DMEM_PROTOCOL_CHECK_EN enables the sticky protocol_error checker
module dmem_block_responder #(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  mem_address,
    input  logic [31:0] mem_writedata,
    output logic [31:0] mem_readdata,
    output logic        mem_busywait,
    output logic        protocol_error
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic op_write;
    logic [5:0] addr_q;
    logic [31:0] data_q;
    logic [7:0] mem [256];
    logic req, access;
    assign req = mem_read | mem_write;
    assign access = (state == WAIT) && (cnt == 4'd0);
    assign mem_busywait = req & (state != ACK);
    // state register
    always_ff @(posedge clock)
        state <= reset ? IDLE : state_nxt;
    // next state: accept in IDLE, count down in WAIT, single ACK cycle
    always_comb begin
        state_nxt = (state == IDLE) ? (req ? WAIT : IDLE) :
                    (state == WAIT) ? ((cnt == 4'd0) ? ACK : WAIT) : IDLE;
    end
    // capture, latency countdown, storage access; reset wipes the array and abandons any access
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 4'd0;
            mem_readdata <= 32'd0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else begin
            if (state == IDLE && req) begin
                op_write <= mem_write;
                addr_q <= mem_address;
                data_q <= mem_writedata;
                cnt <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access && op_write) begin
                mem[{addr_q, 2'b00}] <= data_q[7:0];
                mem[{addr_q, 2'b01}] <= data_q[15:8];
                mem[{addr_q, 2'b10}] <= data_q[23:16];
                mem[{addr_q, 2'b11}] <= data_q[31:24];
            end
            if (access && !op_write)
                mem_readdata <= {mem[{addr_q, 2'b11}], mem[{addr_q, 2'b10}],
                                 mem[{addr_q, 2'b01}], mem[{addr_q, 2'b00}]};
        end
    end
`ifdef DMEM_PROTOCOL_CHECK_EN
    // sticky flag: dual request, or request/address/write-data disturbed while waiting
    always_ff @(posedge clock) begin
        if (reset)
            protocol_error <= 1'b0;
        else if ((mem_read && mem_write) ||
                 (state == WAIT && (!req || mem_address != addr_q ||
                                    (op_write && mem_writedata != data_q))))
            protocol_error <= 1'b1;
    end
`else
    assign protocol_error = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_block_responder.sv
// tb_dmem_block_responder: randomized transactions against a transaction-level memory model
module tb_dmem_block_responder;
    localparam int L = 5;
`ifdef DMEM_PROTOCOL_CHECK_EN
    localparam logic PE_EN = 1'b1;
`else
    localparam logic PE_EN = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset, mem_read, mem_write;
    logic [5:0] mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic mem_busywait, protocol_error;
    logic [31:0] model [64];
    logic exp_busy;
    logic [31:0] exp_rd;
    logic exp_pe;
    logic chk = 1'b0;
    int tests = 0;
    int fails = 0;
    int busy_cnt = 0;

    dmem_block_responder #(.LATENCY(L)) dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare DUT against the model mid-cycle
    always @(negedge clock) begin
        if (chk) begin
            check("busywait", {31'd0, mem_busywait}, {31'd0, exp_busy});
            check("readdata", mem_readdata, exp_rd);
            check("protocol_error", {31'd0, protocol_error}, {31'd0, exp_pe});
            if (mem_busywait === 1'b1) busy_cnt++;
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        exp_rd = 32'd0;
        exp_pe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    // one request raised just after an edge; alt != a moves the address mid-wait; rst_at=1 resets at access edge minus 1
    task automatic txn(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d,
                       input logic [5:0] alt, input bit rst_at);
        mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
        exp_busy = 1'b1;
        for (int i = 0; i <= L; i++) begin
            @(posedge clock); #1;
            if (rst_at && i == L - 1) begin
                reset = 1'b0;
                mem_read = 1'b0; mem_write = 1'b0;
                exp_busy = 1'b0;
                clear_model();
                return;
            end
            if (i == 0 && rd && wr) exp_pe = PE_EN;
            if (i == 1 && alt != a) mem_address = alt;
            if (i == 2 && alt != a) exp_pe = PE_EN;
            if (rst_at && i == L - 2) reset = 1'b1;
            if (i == L) begin
                exp_busy = 1'b0;
                if (wr) model[a] = d;
                else exp_rd = model[a];
            end
        end
        @(posedge clock); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = 6'd0; mem_writedata = 32'd0;
        exp_busy = 1'b0;
        clear_model();
        @(posedge clock); #1;
        do_reset();
        chk = 1'b1;
        idle(2);
        busy_cnt = 0;
        txn(1'b1, 1'b0, 6'd0, 32'd0, 6'd0, 1'b0);
        check("busy_cycles", 32'(busy_cnt), 32'd6);
        check("rd_blk0", mem_readdata, 32'h0);
        txn(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 6'd5, 1'b0);
        idle(1);
        txn(1'b1, 1'b0, 6'd5, 32'd0, 6'd5, 1'b0);
        check("rd_blk5", mem_readdata, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 6'd4, 32'd0, 6'd4, 1'b0);
        check("rd_blk4", mem_readdata, 32'h0);
        txn(1'b1, 1'b0, 6'd6, 32'd0, 6'd6, 1'b0);
        check("rd_blk6", mem_readdata, 32'h0);
        txn(1'b0, 1'b1, 6'd63, 32'h11223344, 6'd63, 1'b0);
        idle(1);
        busy_cnt = 0;
        txn(1'b1, 1'b0, 6'd63, 32'd0, 6'd63, 1'b0);
        check("rd_blk63", mem_readdata, 32'h11223344);
        txn(1'b1, 1'b0, 6'd0, 32'd0, 6'd0, 1'b0);
        check("rd_blk0_b2b", mem_readdata, 32'h0);
        check("b2b_busy_cycles", 32'(busy_cnt), 32'd12);
        idle(1);
        txn(1'b0, 1'b1, 6'd2, 32'hCAFEF00D, 6'd2, 1'b1);
        #1;
        check("busy_after_reset", {31'd0, mem_busywait}, 32'd0);
        idle(1);
        txn(1'b1, 1'b0, 6'd2, 32'd0, 6'd2, 1'b0);
        check("rd_blk2_after_reset", mem_readdata, 32'h0);
        txn(1'b1, 1'b1, 6'd9, 32'h0000AAAA, 6'd9, 1'b0);
        check("dual_pe", {31'd0, protocol_error}, {31'd0, PE_EN});
        txn(1'b1, 1'b0, 6'd9, 32'd0, 6'd9, 1'b0);
        check("rd_blk9", mem_readdata, 32'h0000AAAA);
        do_reset();
        check("pe_cleared", {31'd0, protocol_error}, 32'd0);
        txn(1'b0, 1'b1, 6'd7, 32'h12345678, 6'd7, 1'b0);
        txn(1'b1, 1'b0, 6'd7, 32'd0, 6'd8, 1'b0);
        check("rd_captured_addr", mem_readdata, 32'h12345678);
        idle(3);
        check("pe_sticky", {31'd0, protocol_error}, {31'd0, PE_EN});
        do_reset();
        for (int n = 0; n < 60; n++) begin
            logic w;
            logic [5:0] a;
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            txn(!w, w, a, $urandom, a, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(2);
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
